alu_issue_controller: RTL

- Drives the ALU from the datapath side: accepts one operation request, presents the operands and the 4-bit ctrl code to the ALU, then captures ZHI/ZLO.
- Multiply and divide are handed off to an external multi-cycle unit via a start/done pair. It shares the ALU operand bus and has a completion timeout.
- The captured result is returned on a valid/ready response port. One operation is in flight at a time.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/md_timeout_counter.sv | 29 ++
 rtl/alu_issue_controller.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU ctrl codes, issue-controller state encoding and op classification helpers.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_SHR = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_ROL = 4'b0111;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_NEG = 4'b1010;
    localparam logic [3:0] OP_NOT = 4'b1011;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXEC     = 3'd1,
        ST_MD_START = 3'd2,
        ST_MD_WAIT  = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    function automatic logic is_md(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Codes 1100-1111 are unassigned and answered with an error response.
    function automatic logic is_illegal(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// Clearable up-counter for the multiply/divide wait; tc is high on the cycle whose
// increment brings the count to MD_TIMEOUT-1, i.e. the last cycle worth waiting.
module md_timeout_counter #(
    parameter int MD_TIMEOUT = 64
) (
    input  logic clk,
    input  logic clr,
    input  logic restart,
    input  logic inc,
    output logic tc
);
    localparam int W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [W-1:0] TC_VAL = W'(MD_TIMEOUT - 2);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/alu_issue_controller.sv
// Issues one ALU / multiply-divide op at a time; simple ops respond two edges after accept.
// req_ready only in IDLE; the response is held on rsp_* until rsp_ready handshakes it.
module alu_issue_controller
    import alu_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic [3:0]       alu_ctrl,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_zhi,
    input  logic [31:0]      alu_zlo,
    output logic             md_start,
    input  logic             md_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_hi,
    output logic [31:0]      rsp_lo,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);
    state_t           state, state_nxt;
    logic [3:0]       op_q;
    logic [31:0]      a_q, b_q, hi_q, lo_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept, rsp_fire, md_tc;

    assign accept   = req_valid & req_ready;
    assign rsp_fire = (state == ST_RESP) & rsp_ready;

    md_timeout_counter #(.MD_TIMEOUT(MD_TIMEOUT)) u_md_timeout (
        .clk     (clk),
        .clr     (clr),
        .restart (state == ST_MD_START),
        .inc     ((state == ST_MD_WAIT) && !md_done),
        .tc      (md_tc)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_illegal(req_op)) state_nxt = ST_RESP;
                    else if (is_md(req_op)) state_nxt = ST_MD_START;
                    else                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC:     state_nxt = ST_RESP;
            ST_MD_START: state_nxt = ST_MD_WAIT;
            ST_MD_WAIT:  if (md_done || md_tc) state_nxt = ST_RESP;
            ST_RESP:     if (rsp_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        md_start  = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE:     req_ready = 1'b1;
            ST_MD_START: md_start  = 1'b1;
            ST_RESP:     rsp_valid = 1'b1;
            default:     ;
        endcase
    end

    // Operands stay latched until the next accept so the combinational ALU and
    // the md unit both see a stable bus for the whole operation.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (accept) begin
                op_q <= req_op;
                a_q  <= req_a;
                b_q  <= req_b;
                if (is_illegal(req_op)) begin
                    hi_q  <= '0;
                    lo_q  <= '0;
                    err_q <= 1'b1;
                end
            end
            if (state == ST_EXEC || (state == ST_MD_WAIT && md_done)) begin
                hi_q  <= alu_zhi;
                lo_q  <= alu_zlo;
                err_q <= 1'b0;
            end else if (state == ST_MD_WAIT && md_tc) begin
                hi_q  <= '0;
                lo_q  <= '0;
                err_q <= 1'b1;
            end
            if (rsp_fire) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign alu_ctrl = op_q;
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign rsp_hi   = hi_q;
    assign rsp_lo   = lo_q;
    assign rsp_err  = err_q;
    assign op_count = cnt_q;

endmodule
